// File: rtl/imem_stream_loader.sv
// imem_stream_loader
//   Boot-time loader that sits in front of the single-cycle core. It takes a
//   byte stream (2-byte little-endian word count N, then 4*N image bytes),
//   packs each group of four bytes into a little-endian instruction word and
//   writes the words into instruction memory from byte address 0. The core is
//   held in reset until a complete image has been written.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   start        one-cycle pulse that begins a load (ignored while busy)
//   in_valid     in_data carries a valid byte
//   in_data      stream byte
//   in_ready     loader can take a byte (decoded from state)
//   imem_we      instruction-memory write strobe, one cycle per word
//   imem_addr    byte address of the word being written
//   imem_wdata   assembled instruction word
//   cpu_rst      reset to the core, low only once an image has loaded
//   busy         a load is in progress
//   done         image loaded, core released
//   err          load aborted (oversize length or idle timeout)
//   words_loaded number of words written in the current or last load
module imem_stream_loader #(
  parameter int ADDR_LEN       = 32,
  parameter int INSTR_LEN      = 32,
  parameter int DEPTH_WORDS    = 256,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic                 imem_we,
  output logic [ADDR_LEN-1:0]  imem_addr,
  output logic [INSTR_LEN-1:0] imem_wdata,
  output logic                 cpu_rst,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [15:0]          words_loaded
);

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERROR
  } state_t;

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES - 1);

  state_t        state;
  logic [15:0]   len;
  logic [1:0]    byte_idx;
  logic [TW-1:0] idle_cnt;
  logic          xfer;
  logic          timeout_hit;
  logic [15:0]   len_next;

  // The only unregistered output: ready is a pure decode of the receiving states.
  assign in_ready    = (state == LEN_LO) || (state == LEN_HI) || (state == DATA);
  assign xfer        = in_valid && in_ready;
  // The final idle cycle before the limit aborts the load instead of counting.
  assign timeout_hit = in_ready && !xfer && (idle_cnt == TLIM);
  assign len_next    = {in_data, len[7:0]};

  // words_loaded doubles as the word index, so the write address is simply
  // words_loaded*4 and the completion test compares it against N.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_rst      <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
      len          <= '0;
      byte_idx     <= '0;
      idle_cnt     <= '0;
    end else begin
      imem_we <= 1'b0;

      if (in_ready) begin
        idle_cnt <= xfer ? '0 : idle_cnt + 1'b1;
      end

      if (timeout_hit) begin
        state <= ERROR;
        busy  <= 1'b0;
        err   <= 1'b1;
      end else begin
        case (state)
          IDLE, DONE, ERROR: begin
            if (start) begin
              state        <= LEN_LO;
              busy         <= 1'b1;
              done         <= 1'b0;
              err          <= 1'b0;
              cpu_rst      <= 1'b1;
              words_loaded <= '0;
              byte_idx     <= '0;
              idle_cnt     <= '0;
            end
          end
          LEN_LO: begin
            if (xfer) begin
              len[7:0] <= in_data;
              state    <= LEN_HI;
            end
          end
          LEN_HI: begin
            if (xfer) begin
              len[15:8] <= in_data;
              if (len_next == 16'd0) begin
                state   <= DONE;
                busy    <= 1'b0;
                done    <= 1'b1;
                cpu_rst <= 1'b0;
              end else if (len_next > 16'(DEPTH_WORDS)) begin
                state <= ERROR;
                busy  <= 1'b0;
                err   <= 1'b1;
              end else begin
                state <= DATA;
              end
            end
          end
          DATA: begin
            if (xfer) begin
              imem_wdata[{byte_idx, 3'b000} +: 8] <= in_data;
              byte_idx <= byte_idx + 2'd1;
              if (byte_idx == 2'd3) begin
                state     <= WRITE;
                imem_we   <= 1'b1;
                imem_addr <= ADDR_LEN'({words_loaded, 2'b00});
              end
            end
          end
          WRITE: begin
            words_loaded <= words_loaded + 16'd1;
            if (words_loaded + 16'd1 == len) begin
              state   <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              cpu_rst <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_stream_loader.sv
// tb_imem_stream_loader
//   Self-checking bench for imem_stream_loader. Images are built from word
//   lists by the bench itself; expected writes are simply word i at byte
//   address 4*i. Writes are captured from the memory port and compared
//   against that list.
module tb_imem_stream_loader;

  typedef logic [7:0]  bq_t[$];
  typedef logic [31:0] wq_t[$];

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] words_loaded;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  imem_stream_loader #(
    .ADDR_LEN(32), .INSTR_LEN(32), .DEPTH_WORDS(256), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_rst(cpu_rst), .busy(busy), .done(done),
    .err(err), .words_loaded(words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every memory write for later comparison.
  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic bq_t make_stream(input wq_t w);
    bq_t b;
    int  n = w.size();
    b.push_back(8'(n));
    b.push_back(8'(n >> 8));
    foreach (w[i]) begin
      for (int k = 0; k < 4; k++) b.push_back(w[i][8*k +: 8]);
    end
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_writes();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // mode 0: always valid, 1: valid toggles every cycle, 2: random gaps.
  // With rand_start, start is pulsed at random while the load is busy.
  task automatic stream(input bq_t bytes, input int mode, input bit rand_start);
    int idx = 0;
    int cyc = 0;
    int gap = 0;
    bit hs;
    while (idx < bytes.size() && cyc < 5000) begin
      case (mode)
        0: in_valid = 1'b1;
        1: in_valid = (cyc % 2 == 0);
        default: begin
          in_valid = (gap >= 3) || ($urandom % 4 != 0);
          gap = in_valid ? 0 : gap + 1;
        end
      endcase
      in_data = bytes[idx];
      start   = rand_start && ($urandom % 6 == 0);
      @(negedge clk);
      hs = in_valid && in_ready;
      tick();
      if (hs) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (idx < bytes.size()) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL stream_stall: accepted %0d bytes, required %0d", idx, bytes.size());
    end
  endtask

  task automatic wait_end(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (done || err) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) tick();
    compared++;
    if ({in_ready, imem_we, cpu_rst, busy, done, err} !== 6'b001000) begin
      mismatched++;
      $display("[TB] FAIL reset_flags: got %b, required 001000",
               {in_ready, imem_we, cpu_rst, busy, done, err});
    end
    rst = 1'b0;
    tick();
    compared++;
    if ({imem_addr, imem_wdata, words_loaded} !== 80'd0 ||
        {in_ready, cpu_rst, busy, done, err} !== 5'b01000) begin
      mismatched++;
      $display("[TB] FAIL reset_release: addr=%h data=%h wl=%0d flags=%b, required zeros/01000",
               imem_addr, imem_wdata, words_loaded, {in_ready, cpu_rst, busy, done, err});
    end
  endtask

  task automatic test_normal();
    wq_t w;
    bit  ok;
    w = '{32'h0000_0013, 32'h2000_0008};
    clear_writes();
    pulse_start();
    stream(make_stream(w), 0, 1'b0);
    wait_end(ok);
    compared++;
    if (!ok || wr_addr_q.size() != 2) begin
      mismatched++;
      $display("[TB] FAIL normal_count: ended=%0d writes=%0d, required 1/2", ok, wr_addr_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        compared++;
        if (wr_addr_q[i] !== 32'(4*i) || wr_data_q[i] !== w[i]) begin
          mismatched++;
          $display("[TB] FAIL normal_write%0d: got %h/%h, required %h/%h",
                   i, wr_addr_q[i], wr_data_q[i], 32'(4*i), w[i]);
        end
      end
    end
    compared++;
    if (words_loaded !== 16'd2 || {done, busy, cpu_rst, err} !== 4'b1000) begin
      mismatched++;
      $display("[TB] FAIL normal_status: wl=%0d flags=%b, required 2/1000",
               words_loaded, {done, busy, cpu_rst, err});
    end
  endtask

  task automatic test_zero_length();
    bq_t b;
    bit  ok;
    b = '{8'h00, 8'h00};
    clear_writes();
    pulse_start();
    stream(b, 0, 1'b0);
    ok = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (done) ok = 1'b1;
      if (!ok) tick();
    end
    compared++;
    if (!ok || wr_addr_q.size() != 0 || words_loaded !== 16'd0 || cpu_rst !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL zero_length: done=%0d writes=%0d wl=%0d cpu_rst=%b, required 1/0/0/0",
               done, wr_addr_q.size(), words_loaded, cpu_rst);
    end
  endtask

  task automatic test_oversize();
    bq_t b;
    bit  ok;
    b = '{8'h01, 8'h01};
    clear_writes();
    pulse_start();
    stream(b, 0, 1'b0);
    wait_end(ok);
    repeat (2) tick();
    compared++;
    if (!ok || {err, done, cpu_rst, in_ready, busy} !== 5'b10100 || wr_addr_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL oversize: flags(err,done,cpu_rst,in_ready,busy)=%b writes=%0d, required 10100/0",
               {err, done, cpu_rst, in_ready, busy}, wr_addr_q.size());
    end
  endtask

  task automatic test_backpressure();
    wq_t w;
    bq_t b;
    bit  ok;
    w = '{$urandom};
    clear_writes();
    pulse_start();
    stream(make_stream(w), 1, 1'b0);
    wait_end(ok);
    compared++;
    if (!ok || wr_data_q.size() != 1 || wr_data_q[0] !== w[0] || wr_addr_q[0] !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL toggle_word: writes=%0d data=%h, required 1/%h",
               wr_data_q.size(), (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hx, w[0]);
    end
  endtask

  task automatic test_write_cycle();
    wq_t w;
    bq_t b;
    bq_t first;
    bq_t rest;
    bit  ok;
    w = '{$urandom, $urandom};
    b = make_stream(w);
    for (int i = 0; i < 6; i++) first.push_back(b[i]);
    for (int i = 7; i < 10; i++) rest.push_back(b[i]);
    clear_writes();
    pulse_start();
    stream(first, 0, 1'b0);
    compared++;
    if (imem_we !== 1'b1 || in_ready !== 1'b0 || imem_addr !== 32'h0 || imem_wdata !== w[0]) begin
      mismatched++;
      $display("[TB] FAIL write_latency: we=%b ready=%b addr=%h data=%h, required 1/0/0/%h",
               imem_we, in_ready, imem_addr, imem_wdata, w[0]);
    end
    in_valid = 1'b1;
    in_data  = b[6];
    tick();
    compared++;
    if (imem_we !== 1'b0 || in_ready !== 1'b1 || words_loaded !== 16'd1) begin
      mismatched++;
      $display("[TB] FAIL write_hold: we=%b ready=%b wl=%0d, required 0/1/1",
               imem_we, in_ready, words_loaded);
    end
    tick();
    in_valid = 1'b0;
    stream(rest, 0, 1'b0);
    wait_end(ok);
    compared++;
    if (!ok || wr_data_q.size() != 2 || wr_data_q[1] !== w[1] || wr_addr_q[1] !== 32'h4) begin
      mismatched++;
      $display("[TB] FAIL write_held_byte: writes=%0d data1=%h, required 2/%h",
               wr_data_q.size(), (wr_data_q.size() > 1) ? wr_data_q[1] : 32'hx, w[1]);
    end
  endtask

  task automatic test_timeout();
    bq_t b;
    b = '{8'h01, 8'h00, 8'h5a, 8'ha5};
    clear_writes();
    pulse_start();
    stream(b, 0, 1'b0);
    repeat (7) tick();
    compared++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL timeout_early: err=%b busy=%b after 7 idle, required 0/1", err, busy);
    end
    tick();
    compared++;
    if ({err, busy, cpu_rst} !== 3'b101 || words_loaded !== 16'd0 || wr_addr_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL timeout_abort: flags=%b wl=%0d writes=%0d, required 101/0/0",
               {err, busy, cpu_rst}, words_loaded, wr_addr_q.size());
    end
  endtask

  task automatic test_random_loads(input int iters);
    wq_t w;
    bit  ok;
    int  n;
    for (int it = 0; it < iters; it++) begin
      w.delete();
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) w.push_back($urandom);
      clear_writes();
      pulse_start();
      compared++;
      if ({busy, done, err, cpu_rst} !== 4'b1001) begin
        mismatched++;
        $display("[TB] FAIL rand%0d_start: flags=%b, required 1001", it, {busy, done, err, cpu_rst});
      end
      stream(make_stream(w), $urandom_range(0, 2), 1'b1);
      wait_end(ok);
      compared++;
      if (!ok || wr_addr_q.size() != n) begin
        mismatched++;
        $display("[TB] FAIL rand%0d_count: ended=%0d writes=%0d, required 1/%0d",
                 it, ok, wr_addr_q.size(), n);
      end else begin
        for (int i = 0; i < n; i++) begin
          compared++;
          if (wr_addr_q[i] !== 32'(4*i) || wr_data_q[i] !== w[i]) begin
            mismatched++;
            $display("[TB] FAIL rand%0d_write%0d: got %h/%h, required %h/%h",
                     it, i, wr_addr_q[i], wr_data_q[i], 32'(4*i), w[i]);
          end
        end
      end
      compared++;
      if (words_loaded !== 16'(n) || {done, busy, err, cpu_rst} !== 4'b1000) begin
        mismatched++;
        $display("[TB] FAIL rand%0d_status: wl=%0d flags=%b, required %0d/1000",
                 it, words_loaded, {done, busy, err, cpu_rst}, n);
      end
    end
  endtask

  task automatic test_max_length();
    wq_t w;
    bit  ok;
    int  bad = 0;
    for (int i = 0; i < 256; i++) w.push_back($urandom);
    clear_writes();
    pulse_start();
    stream(make_stream(w), 0, 1'b0);
    wait_end(ok);
    compared++;
    if (!ok || done !== 1'b1 || words_loaded !== 16'd256 || wr_addr_q.size() != 256) begin
      mismatched++;
      $display("[TB] FAIL max_length: done=%b wl=%0d writes=%0d, required 1/256/256",
               done, words_loaded, wr_addr_q.size());
    end else begin
      for (int i = 0; i < 256; i++) begin
        if (wr_addr_q[i] !== 32'(4*i) || wr_data_q[i] !== w[i]) bad++;
      end
      compared++;
      if (bad != 0 || wr_addr_q[255] !== 32'h3fc) begin
        mismatched++;
        $display("[TB] FAIL max_length_data: %0d bad writes, last addr %h, required 0/000003fc",
                 bad, wr_addr_q[255]);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    bq_t b;
    b = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33};
    clear_writes();
    pulse_start();
    stream(b, 0, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h44;
    #2;
    rst = 1'b1;
    #1;
    compared++;
    if ({in_ready, imem_we, cpu_rst, busy, done, err} !== 6'b001000 ||
        {imem_addr, imem_wdata, words_loaded} !== 80'd0) begin
      mismatched++;
      $display("[TB] FAIL rst_mid_load: flags=%b addr=%h data=%h wl=%0d, required 001000/0/0/0",
               {in_ready, imem_we, cpu_rst, busy, done, err}, imem_addr, imem_wdata, words_loaded);
    end
    repeat (2) tick();
    in_valid = 1'b0;
    rst = 1'b0;
    repeat (2) tick();
    compared++;
    if (wr_addr_q.size() != 0 || {in_ready, cpu_rst, busy, done, err} !== 5'b01000) begin
      mismatched++;
      $display("[TB] FAIL rst_mid_load_after: writes=%0d flags=%b, required 0/01000",
               wr_addr_q.size(), {in_ready, cpu_rst, busy, done, err});
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_zero_length();
    test_oversize();
    test_backpressure();
    test_write_cycle();
    test_timeout();
    test_random_loads(2);
    test_max_length();
    test_reset_mid_load();
    test_random_loads(6);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
